// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter: data/index widths,
// source codes reported on the write port, and internal source slot numbers.
package wb_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int REG_IDX_WIDTH = 5;
    localparam logic [REG_IDX_WIDTH-1:0] REG_X0 = '0;

    // Starvation counters are 4 bits wide, so the limit must stay within 1..15.
    localparam int CNT_WIDTH = 4;
    localparam int NUM_SRC   = 3;

    // Slot numbers used to index the per-source arrays inside the arbiter.
    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

    // Source code driven on wb_src_o alongside each write.
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_LSU  = 2'd2,
        WB_SRC_MDU  = 2'd3
    } wb_src_e;

    // Map an internal slot to the code reported on the write port.
    function automatic wb_src_e src_code(input int slot);
        case (slot)
            SRC_ALU: src_code = WB_SRC_ALU;
            SRC_LSU: src_code = WB_SRC_LSU;
            SRC_MDU: src_code = WB_SRC_MDU;
            default: src_code = WB_SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the three result handshakes plus the registered write port.
// The slave modport is the arbiter's view; master is the sources/regfile side.
interface wb_arbiter_if #(
    parameter int XLEN          = 32,
    parameter int REG_IDX_WIDTH = 5
);

    logic                     alu_valid_i;
    logic                     alu_ready_o;
    logic [REG_IDX_WIDTH-1:0] alu_rd_idx_i;
    logic [XLEN-1:0]          alu_rd_wdata_i;

    logic                     lsu_valid_i;
    logic                     lsu_ready_o;
    logic [REG_IDX_WIDTH-1:0] lsu_rd_idx_i;
    logic [XLEN-1:0]          lsu_rd_wdata_i;

    logic                     mdu_valid_i;
    logic                     mdu_ready_o;
    logic [REG_IDX_WIDTH-1:0] mdu_rd_idx_i;
    logic [XLEN-1:0]          mdu_rd_wdata_i;

    logic                     wb_rd_en_o;
    logic [REG_IDX_WIDTH-1:0] wb_rd_idx_o;
    logic [XLEN-1:0]          wb_rd_wdata_o;
    logic [1:0]               wb_src_o;

    modport slave (
        input  alu_valid_i, alu_rd_idx_i, alu_rd_wdata_i,
        input  lsu_valid_i, lsu_rd_idx_i, lsu_rd_wdata_i,
        input  mdu_valid_i, mdu_rd_idx_i, mdu_rd_wdata_i,
        output alu_ready_o, lsu_ready_o, mdu_ready_o,
        output wb_rd_en_o, wb_rd_idx_o, wb_rd_wdata_o, wb_src_o
    );

    modport master (
        output alu_valid_i, alu_rd_idx_i, alu_rd_wdata_i,
        output lsu_valid_i, lsu_rd_idx_i, lsu_rd_wdata_i,
        output mdu_valid_i, mdu_rd_idx_i, mdu_rd_wdata_i,
        input  alu_ready_o, lsu_ready_o, mdu_ready_o,
        input  wb_rd_en_o, wb_rd_idx_o, wb_rd_wdata_o, wb_src_o
    );

endinterface

// File: rtl/wb_arbiter_starve_cnt.sv
// Per-source starvation counter: counts consecutive cycles a valid source
// loses arbitration, saturating at STARVE_LIM, and flags the source urgent
// once the limit is reached.
module wb_starve_cnt
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic grant,
    output logic urgent
);

    localparam logic [CNT_WIDTH-1:0] LIM = CNT_WIDTH'(STARVE_LIM);

    logic [CNT_WIDTH-1:0] count_reg;

    // Clear when idle or served, otherwise count lost cycles up to the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (!valid || grant) begin
            count_reg <= '0;
        end else if (count_reg != LIM) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign urgent = (count_reg == LIM);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks at most one of ALU/LSU/MDU per cycle (fixed
// priority LSU > MDU > ALU, with starving sources promoted to urgent) and
// registers the winner onto the register-file write port. Writes to x0 are
// accepted but do not raise the write enable.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN          = wb_arbiter_pkg::XLEN,
    parameter int REG_IDX_WIDTH = wb_arbiter_pkg::REG_IDX_WIDTH,
    parameter int STARVE_LIM    = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    logic [NUM_SRC-1:0]       valid;
    logic [NUM_SRC-1:0]       urgent;
    logic [NUM_SRC-1:0]       urgent_valid;
    logic [NUM_SRC-1:0]       grant;
    logic [REG_IDX_WIDTH-1:0] idx   [NUM_SRC];
    logic [XLEN-1:0]          wdata [NUM_SRC];

    logic [REG_IDX_WIDTH-1:0] sel_idx;
    logic [XLEN-1:0]          sel_wdata;
    wb_src_e                  sel_code;

    logic                     en_reg;
    logic [REG_IDX_WIDTH-1:0] idx_reg;
    logic [XLEN-1:0]          wdata_reg;
    wb_src_e                  src_reg;

    // Gather the named source ports into slot-indexed arrays.
    assign valid[SRC_ALU] = bus.alu_valid_i;
    assign valid[SRC_LSU] = bus.lsu_valid_i;
    assign valid[SRC_MDU] = bus.mdu_valid_i;
    assign idx[SRC_ALU]   = bus.alu_rd_idx_i;
    assign idx[SRC_LSU]   = bus.lsu_rd_idx_i;
    assign idx[SRC_MDU]   = bus.mdu_rd_idx_i;
    assign wdata[SRC_ALU] = bus.alu_rd_wdata_i;
    assign wdata[SRC_LSU] = bus.lsu_rd_wdata_i;
    assign wdata[SRC_MDU] = bus.mdu_rd_wdata_i;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_starve
            wb_starve_cnt #(
                .STARVE_LIM (STARVE_LIM)
            ) u_starve_cnt (
                .clk    (clk),
                .rst    (rst),
                .valid  (valid[gi]),
                .grant  (grant[gi]),
                .urgent (urgent[gi])
            );
        end
    endgenerate

    // One-hot pick of the highest fixed-priority requester: LSU > MDU > ALU.
    function automatic logic [NUM_SRC-1:0] pick_first(input logic [NUM_SRC-1:0] req);
        pick_first = '0;
        if (req[SRC_LSU])      pick_first[SRC_LSU] = 1'b1;
        else if (req[SRC_MDU]) pick_first[SRC_MDU] = 1'b1;
        else if (req[SRC_ALU]) pick_first[SRC_ALU] = 1'b1;
    endfunction

    // Urgent valid sources take precedence; reset suppresses every grant.
    always_comb begin
        urgent_valid = valid & urgent;
        grant        = '0;
        if (!rst) begin
            grant = pick_first((|urgent_valid) ? urgent_valid : valid);
        end
    end

    // Route the granted source's payload towards the output register.
    always_comb begin
        sel_idx   = '0;
        sel_wdata = '0;
        sel_code  = WB_SRC_NONE;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_idx   = idx[i];
                sel_wdata = wdata[i];
                sel_code  = src_code(i);
            end
        end
    end

    // Write port register: one cycle after acceptance; x0 and idle cycles
    // drop the enable while idx/wdata hold their last written values.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_reg    <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            src_reg   <= WB_SRC_NONE;
        end else if ((|grant) && (sel_idx != REG_X0[REG_IDX_WIDTH-1:0])) begin
            en_reg    <= 1'b1;
            idx_reg   <= sel_idx;
            wdata_reg <= sel_wdata;
            src_reg   <= sel_code;
        end else begin
            en_reg    <= 1'b0;
            src_reg   <= WB_SRC_NONE;
        end
    end

    assign bus.alu_ready_o   = grant[SRC_ALU];
    assign bus.lsu_ready_o   = grant[SRC_LSU];
    assign bus.mdu_ready_o   = grant[SRC_MDU];
    assign bus.wb_rd_en_o    = en_reg;
    assign bus.wb_rd_idx_o   = idx_reg;
    assign bus.wb_rd_wdata_o = wdata_reg;
    assign bus.wb_src_o      = src_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_wb_arbiter;

    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(32), .REG_IDX_WIDTH(5)) bus ();

    wb_arbiter #(
        .XLEN          (32),
        .REG_IDX_WIDTH (5),
        .STARVE_LIM    (LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Source-side stimulus; slot 0 = ALU, 1 = LSU, 2 = MDU.
    logic        src_v [3];
    logic [4:0]  src_i [3];
    logic [31:0] src_d [3];

    assign bus.alu_valid_i    = src_v[0];
    assign bus.alu_rd_idx_i   = src_i[0];
    assign bus.alu_rd_wdata_i = src_d[0];
    assign bus.lsu_valid_i    = src_v[1];
    assign bus.lsu_rd_idx_i   = src_i[1];
    assign bus.lsu_rd_wdata_i = src_d[1];
    assign bus.mdu_valid_i    = src_v[2];
    assign bus.mdu_rd_idx_i   = src_i[2];
    assign bus.mdu_rd_wdata_i = src_d[2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: lost-cycle tallies and the expected write port.
    int          lost [3];
    bit          exp_en;
    bit          exp_zero;
    logic [4:0]  exp_idx;
    logic [31:0] exp_data;
    int          exp_src;
    int          accepted;
    int          cyc = 0;

    // Observed DUT values captured in the last step.
    logic [2:0]  rdy_act;
    logic        obs_en;
    logic [4:0]  obs_idx;
    logic [31:0] obs_data;
    logic [1:0]  obs_src;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Winner by the rules: starving sources first, each group in LSU > MDU > ALU order.
    function automatic int model_grant();
        int order [3];
        order = '{1, 2, 0};
        if (rst) return -1;
        foreach (order[k]) if (src_v[order[k]] && lost[order[k]] >= LIM) return order[k];
        foreach (order[k]) if (src_v[order[k]]) return order[k];
        return -1;
    endfunction

    // One clock: compare at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        int g;
        @(negedge clk);
        cyc++;
        rdy_act  = {bus.mdu_ready_o, bus.lsu_ready_o, bus.alu_ready_o};
        obs_en   = bus.wb_rd_en_o;
        obs_idx  = bus.wb_rd_idx_o;
        obs_data = bus.wb_rd_wdata_o;
        obs_src  = bus.wb_src_o;
        g = model_grant();
        for (int s = 0; s < 3; s++)
            check($sformatf("ready[%0d]", s), rdy_act[s], (g == s));
        check("wb_rd_en", obs_en, exp_en);
        check("wb_src", obs_src, exp_src);
        if (exp_en || exp_zero) begin
            check("wb_rd_idx", obs_idx, exp_idx);
            check("wb_rd_wdata", obs_data, exp_data);
        end
        if (rst) begin
            exp_en = 0; exp_src = 0; exp_idx = '0; exp_data = '0; exp_zero = 1;
            for (int s = 0; s < 3; s++) lost[s] = 0;
        end else begin
            if (g >= 0 && src_i[g] != 0) begin
                exp_en = 1; exp_idx = src_i[g]; exp_data = src_d[g];
                exp_src = g + 1; exp_zero = 0;
            end else begin
                exp_en = 0; exp_src = 0;
            end
            for (int s = 0; s < 3; s++) begin
                if (!src_v[s] || g == s) lost[s] = 0;
                else if (lost[s] < LIM)  lost[s] = lost[s] + 1;
            end
        end
        if (g >= 0)
            $display("cycle %0d accept src=%0d idx=%0d data=%08h", cyc, g + 1, src_i[g], src_d[g]);
        accepted = g;
        @(posedge clk);
        #1;
    endtask

    // Sources that are idle or were just accepted may present a new result.
    task automatic refresh(input int pct);
        for (int s = 0; s < 3; s++) begin
            if (!src_v[s] || accepted == s) begin
                src_v[s] = ($urandom_range(0, 99) < pct);
                src_i[s] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                src_d[s] = $urandom;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (!(src_v[0] || src_v[1] || src_v[2])) break;
            step();
            refresh(0);
        end
        check("drain_bound", (src_v[0] || src_v[1] || src_v[2]), 1'b0);
    endtask

    task automatic set_src(input int s, input logic v, input logic [4:0] i, input logic [31:0] d);
        src_v[s] = v; src_i[s] = i; src_d[s] = d;
    endtask

    initial begin
        int alu_win;
        int lsu_after;
        int en_count;
        int pct_tab [5];
        pct_tab = '{90, 50, 100, 20, 75};
        accepted = -1;
        for (int s = 0; s < 3; s++) begin
            lost[s] = 0;
            set_src(s, 1'b1, 5'(s + 1), 32'h100 * (s + 1));
        end
        exp_en = 0; exp_src = 0; exp_idx = '0; exp_data = '0; exp_zero = 1;

        // Reset held with every source valid: nothing may be accepted.
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_release_lsu_ready", rdy_act[1], 1'b1);
        refresh(0);
        drain();
        step();

        // Single ALU result.
        set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        check("single_alu_ready", rdy_act[0], 1'b1);
        refresh(0);
        step();
        check("single_alu_wb", {obs_en, obs_idx, obs_data, obs_src}, {1'b1, 5'd5, 32'hDEADBEEF, 2'd1});
        step();
        check("single_alu_after", obs_en, 1'b0);

        // x0 destination is accepted but produces no write.
        set_src(2, 1'b1, 5'd0, 32'h1234);
        step();
        check("x0_mdu_ready", rdy_act[2], 1'b1);
        refresh(0);
        step();
        check("x0_no_write", {obs_en, obs_src}, {1'b0, 2'd0});

        // LSU beats ALU, ALU follows on the next cycle.
        set_src(1, 1'b1, 5'd3, 32'h11);
        set_src(0, 1'b1, 5'd4, 32'h22);
        step();
        check("prio_lsu_first", rdy_act, 3'b010);
        refresh(0);
        step();
        check("prio_alu_second", {rdy_act, obs_en, obs_idx}, {3'b001, 1'b1, 5'd3});
        refresh(0);
        step();
        check("prio_write_two", {obs_en, obs_idx, obs_data}, {1'b1, 5'd4, 32'h22});
        step();

        // Starvation: ALU held against continuously valid LSU.
        alu_win = 0;
        lsu_after = 0;
        set_src(0, 1'b1, 5'd7, 32'hA5A5A5A5);
        set_src(1, 1'b1, 5'd9, $urandom);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (rdy_act[0] && alu_win == 0) alu_win = c;
            if (c == 6) lsu_after = rdy_act[1];
            if (accepted == 1) set_src(1, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            if (accepted == 0) src_v[0] = 1'b0;
        end
        check("starve_alu_win_cycle", alu_win, 5);
        check("starve_lsu_resumes", lsu_after, 1);
        refresh(0);
        drain();
        step();

        // Back-to-back MDU results idx 1..8.
        en_count = 0;
        for (int k = 1; k <= 8; k++) begin
            set_src(2, 1'b1, 5'(k), 32'h100 * k);
            step();
            en_count += int'(obs_en);
        end
        src_v[2] = 1'b0;
        step();
        en_count += int'(obs_en);
        step();
        en_count += int'(obs_en);
        check("b2b_write_count", en_count, 8);

        // Randomized traffic with occasional reset pulses mid-operation.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            step();
            refresh(pct_tab[(c / 300) % 5]);
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-stage arbiter: the producer side of the register file's single write port.
- Accepts completed results from three execution sources (ALU, LSU, MDU) over valid/ready handshakes and selects at most one per cycle.
- Drives the selected result onto the registered write port (wb_rd_en/idx/wdata) one cycle after acceptance.
- Fixed priority with a per-source starvation guard; writes to x0 are absorbed.

Parameters:
- XLEN, 32, data width of results and write port.
- REG_IDX_WIDTH, 5, register index width.
- STARVE_LIM, 4, consecutive lost-arbitration cycles before a source becomes urgent (legal range 1..15).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (sampled on rising clk edge).
- alu_valid_i  in  1  ALU result valid.
- alu_ready_o  out  1  ALU result accepted this cycle.
- alu_rd_idx_i  in  REG_IDX_WIDTH  ALU destination register.
- alu_rd_wdata_i  in  XLEN  ALU result.
- lsu_valid_i / lsu_ready_o / lsu_rd_idx_i / lsu_rd_wdata_i  same as ALU set, for load data.
- mdu_valid_i / mdu_ready_o / mdu_rd_idx_i / mdu_rd_wdata_i  same as ALU set, for mul/div results.
- wb_rd_en_o  out  1  register-file write enable (registered).
- wb_rd_idx_o  out  REG_IDX_WIDTH  register-file write index (registered).
- wb_rd_wdata_o  out  XLEN  register-file write data (registered).
- wb_src_o  out  2  source of current write: 0 none, 1 ALU, 2 LSU, 3 MDU (registered; debug and perf).

Behaviour:
- Reset (rst=1 at a clock edge):
  - wb_rd_en_o=0, wb_rd_idx_o=0, wb_rd_wdata_o=0, wb_src_o=0.
  - All starvation counters = 0.
  - While rst=1, all *_ready_o = 0 (combinationally gated). No transfer completes during reset, including a transfer pending when reset asserts mid-operation.
- Handshake:
  - A transfer completes when valid_i & ready_o are both high in the same cycle.
  - ready_o is combinational from the current valid_i values and the counters; it never depends on any source's ready_o.
  - Sources hold valid/idx/wdata stable until accepted; the arbiter need not tolerate a source dropping valid before acceptance.
  - At most one ready_o is high per cycle. A ready_o is never high when its valid_i is low.
- Urgency:
  - A source is urgent when its counter == STARVE_LIM.
  - If any valid source is urgent, the grant goes to the highest-fixed-priority urgent valid source.
  - Otherwise the grant goes to the highest-fixed-priority valid source.
  - Fixed priority order: LSU > MDU > ALU.
- Starvation counters, one per source, width 4, saturating at STARVE_LIM:
  - valid_i=0: counter clears to 0.
  - valid_i=1 and granted: counter clears to 0.
  - valid_i=1 and not granted: counter increments, saturating at STARVE_LIM.
- Output register, updated every cycle:
  - Grant to a source with rd_idx != 0: next cycle wb_rd_en_o=1, idx/wdata = the accepted values, wb_src_o = source code.
  - Grant to a source with rd_idx == 0: the source is still accepted (ready_o=1); next cycle wb_rd_en_o=0 and wb_src_o=0, idx/wdata hold previous values.
  - No grant: next cycle wb_rd_en_o=0, wb_src_o=0, idx/wdata hold previous values.
- Latency:
  - Exactly one cycle from acceptance to wb_rd_en_o assertion.
  - Sustained throughput of one write per cycle.
  - No output backpressure: the register file always accepts.
- Simultaneous events:
  - All three valid with no urgency: LSU wins.
  - LSU and ALU both urgent: LSU wins; ALU stays saturated and wins the next cycle in which LSU is not urgent or not valid.
- Idx/wdata are don't-care whenever wb_rd_en_o=0. Bench must not check them in that case.

Decomposition:
- Shared defines header supplies XLEN, REG_IDX_WIDTH and REG_X0, plus new constants WB_SRC_NONE/ALU/LSU/MDU (2-bit).
- One sub-module, wb_starve_cnt: per-source saturating counter with urgent output, instantiated three times.
- Grant logic and output register stay in wb_arbiter.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all valid=1 -> all ready_o=0, wb_rd_en_o=0, wb_src_o=0. First cycle after release: lsu_ready_o=1.
- Single ALU: alu_valid=1, idx=5, wdata=0xDEADBEEF for one cycle -> alu_ready_o=1 same cycle. Next cycle wb_rd_en_o=1, idx=5, wdata=0xDEADBEEF, wb_src_o=1. Cycle after that wb_rd_en_o=0.
- x0 write: mdu_valid=1, idx=0, wdata=0x1234 -> mdu_ready_o=1. Next cycle wb_rd_en_o=0, wb_src_o=0.
- Priority: LSU (idx=3, 0x11) and ALU (idx=4, 0x22) valid together -> LSU accepted first. ALU is accepted the following cycle, in that cycle wb_rd_en_o=1 with idx=3. Writes appear on consecutive cycles: idx 3 then 4.
- Starvation, STARVE_LIM=4: LSU valid continuously with new data each acceptance, ALU valid held constant -> ALU loses 4 cycles, counter reaches 4, ALU granted on the 5th cycle over LSU. ALU counter returns to 0; LSU resumes winning.
- Back-to-back throughput: MDU presents 8 results idx 1..8 on consecutive cycles with no competition -> 8 consecutive wb_rd_en_o=1 cycles, in order, each one cycle after its acceptance.
